// File: rtl/serial_alu_seq_pkg.sv
// Shared encodings for the bit-serial ALU: op codes {ainvert, binvert, s[1:0]} and FSM states.
package serial_alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_alu_seq_slice.sv
// One-bit ALU slice (AND / OR / full-add / less) with optional operand inversion; purely combinational.
module alu_bit_slice (
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       cin,
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic [1:0] s,
  output logic       result,
  output logic       cout,
  output logic       sum
);

  logic w_a;
  logic w_b;

  assign w_a  = a ^ ainvert;
  assign w_b  = b ^ binvert;
  assign sum  = w_a ^ w_b ^ cin;
  assign cout = (w_a & w_b) | (cin & (w_a ^ w_b));

  always_comb begin
    result = 1'b0;
    case (s)
      2'b00:   result = w_a & w_b;
      2'b01:   result = w_a | w_b;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one bit per cycle, LSB first, through a single alu_bit_slice.
// Optional overflow output is enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu_seq
  import serial_alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [WIDTH-1:0] w_result_next;
  logic             w_accept;
  logic             w_last;
  logic             w_bit;
  logic             w_cout;
  logic             w_sum;
  logic             w_v;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // On the MSB cycle r_carry is the carry into the MSB, so this is signed overflow
  assign w_v      = r_carry ^ w_cout;

  alu_bit_slice u_slice (
    .ainvert (r_op[3]),
    .binvert (r_op[2]),
    .cin     (r_carry),
    .a       (r_a[r_cnt]),
    .b       (r_b[r_cnt]),
    .less    (1'b0),
    .s       (r_op[1:0]),
    .result  (w_bit),
    .cout    (w_cout),
    .sum     (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Less-type ops resolve their sign bit only once the MSB sum and overflow are known
  always_comb begin
    w_result_next        = r_result;
    w_result_next[r_cnt] = w_bit;
    if (w_last && (r_op[1:0] == 2'b11)) w_result_next[0] = w_sum ^ w_v;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_carry  <= op[2];
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_cnt    <= r_cnt + 1'b1;
      r_carry  <= w_cout;
      r_result <= w_result_next;
      if (w_last) r_zero <= (w_result_next == '0);
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_ovf <= ((r_op == ALU_ADD) || (r_op == ALU_SUB)) ? w_v : 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized and directed bench for serial_alu_seq (WIDTH=32) against a word-level reference model.
module tb_serial_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [3:0]   op_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf_obs;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SERIAL_ALU_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_in),
    .b      (b_in),
    .op     (op_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
`ifdef SERIAL_ALU_OVF_EN
    , .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference: invert operands, then AND/OR/ADD, or signed less-than from the full sum
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                       output logic [W-1:0] res, output logic z, output logic v_out);
    logic [W-1:0] ai, bi;
    logic [W:0]   full;
    logic [W-1:0] low;
    logic         cin, c_msb_in, v;
    ai   = op[3] ? ~a : a;
    bi   = op[2] ? ~b : b;
    cin  = op[2];
    full = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, cin};
    low  = {1'b0, ai[W-2:0]} + {1'b0, bi[W-2:0]} + {{(W-1){1'b0}}, cin};
    c_msb_in = low[W-1];
    v    = c_msb_in ^ full[W];
    case (op[1:0])
      2'b00:   res = ai & bi;
      2'b01:   res = ai | bi;
      2'b10:   res = full[W-1:0];
      default: res = {{(W-1){1'b0}}, full[W-1] ^ v};
    endcase
    z = (res == '0);
    v_out = (op == 4'b0010 || op == 4'b0110) ? v : 1'b0;
  endtask

  // Issue one op (caller is away from a rising edge); optionally pulse start again mid-run
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                       input int inj, input string tag);
    logic [W-1:0] er;
    logic         ez, ev;
    int           edges;
    model(a, b, op, er, ez, ev);
    a_in = a; b_in = b; op_in = op; start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    chk({tag, "_busy_acc"}, 64'(busy), 64'd1);
    while (1) begin
      @(negedge clk);
      start = (inj >= 0 && edges == inj);
      if (start) begin a_in = $urandom; b_in = $urandom; op_in = 4'($urandom); end
      @(posedge clk); #1;
      edges++;
      if (done || edges > 100) break;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(edges), 64'(W + 1));
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
`ifdef SERIAL_ALU_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf_obs), 64'(ev));
`endif
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_held"}, 64'(result), 64'(er));
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_ovf", 64'(ovf_obs), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(32'h0000_0005, 32'h0000_0003, 4'b0010, -1, "add");
    do_op(32'h1234_5678, 32'h1234_5678, 4'b0110, -1, "sub_eq");
    do_op(32'h8000_0000, 32'h0000_0001, 4'b0110, -1, "sub_ovf");
    chk("sub_ovf_val", 64'(result), 64'h7FFF_FFFF);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, -1, "slt_neg");
    chk("slt_neg_val", 64'(result), 64'd1);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, -1, "slt_ovf");
    chk("slt_ovf_val", 64'(result), 64'd0);
    do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, -1, "and");
    chk("and_val", 64'(result), 64'hF000_F000);
    do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, -1, "or");
    chk("or_val", 64'(result), 64'hFFF0_FFF0);
    do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1100, -1, "nor");
    chk("nor_val", 64'(result), 64'h000F_000F);
    do_op(32'h0000_1111, 32'h0000_2222, 4'b0010, 10, "ign_start");

    // Abort mid-run with reset
    a_in = 32'hDEAD_BEEF; b_in = 32'h0123_4567; op_in = 4'b0010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    do_op(32'h0000_0005, 32'h0000_0003, 4'b0010, -1, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      do_op(ra, rb, 4'($urandom), -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; the legal range is 2..64.
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  is the reset: asynchronous, active-high.
REQ-004 Port start  input  1  requests an operation; it SHALL be sampled only in IDLE.
REQ-005 Port a  input  WIDTH  is operand A; it SHALL be latched when start is accepted.
REQ-006 Port b  input  WIDTH  is operand B; it SHALL be latched when start is accepted.
REQ-007 Port op  input  4  is the ALU control {ainvert, binvert, s[1:0]}; it SHALL be latched when start is accepted.
REQ-008 Port busy  output  1  SHALL be high while an operation is in progress.
REQ-009 Port done  output  1  SHALL be a one-cycle pulse marking that result is valid.
REQ-010 Port result  output  WIDTH  is the operation result; it SHALL be held until the next accepted start.
REQ-011 Port zero  output  1  SHALL be high when result equals 0; it SHALL be held with result.

Function
REQ-012 The datapath SHALL process one bit per cycle, LSB first, through a single 1-bit ALU slice.
REQ-013 The slice SHALL compute: s=00 AND; s=01 OR; s=10 sum with carry; s=11 the slice's less input; ainvert and binvert invert a_i and b_i before the operation.
REQ-014 Supported op encodings SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-015 Any other op encoding SHALL still execute per REQ-013 bit semantics; it SHALL NOT hang the block or raise an error.
REQ-016 The carry register SHALL be initialised to binvert at start acceptance and SHALL update with the slice carry-out every RUN cycle.
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 In IDLE, start=1 SHALL latch a, b and op, clear the bit counter, and move to RUN.
REQ-019 RUN SHALL last exactly WIDTH cycles; each cycle it SHALL shift the slice result bit into result[cnt] and increment cnt.
REQ-020 At cnt==WIDTH-1, the FSM SHALL move to DONE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 Latency: done SHALL be high in the cycle that begins WIDTH+1 rising edges after the edge that accepted start (33 for WIDTH=32).
REQ-023 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-025 start held high through DONE SHALL be accepted in the IDLE cycle that follows; back-to-back throughput is therefore one op per WIDTH+2 cycles.
REQ-026 For SLT, bits 1..WIDTH-1 of result SHALL be 0; on the last RUN cycle, result[0] SHALL be set to (MSB sum) XOR (signed overflow), giving a correct signed compare.
REQ-027 During RUN, result SHALL show partial, not-yet-valid values.
REQ-028 zero SHALL be computed on entry to DONE from the final result.

Reset
REQ-029 While rst=1, state SHALL be IDLE, cnt=0, carry=0, result=0, zero=0, busy=0, done=0, and ovf=0 when present.
REQ-030 Reset asserted mid-operation SHALL abort the operation, with no done pulse.
REQ-031 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-032 The block SHALL be configured by macro SERIAL_ALU_OVF_EN.
REQ-033 With SERIAL_ALU_OVF_EN defined, the block SHALL have output port ovf (1 bit), equal to the carry into the MSB XOR the carry out of the MSB for ADD/SUB, 0 for all other ops, and updated and held like zero.
REQ-034 Without SERIAL_ALU_OVF_EN, the ovf port and its logic SHALL be absent; SLT overflow correction (REQ-026) SHALL remain.

Structure
REQ-035 A shared package/header SHALL hold the op encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR) and the state encodings (ST_IDLE, ST_RUN, ST_DONE).
REQ-036 Sub-module alu_bit_slice SHALL be purely combinational, with inputs ainvert, binvert, cin, a, b, less, s[1:0] and outputs result, cout, sum.
REQ-037 serial_alu_seq SHALL instantiate alu_bit_slice once; less SHALL be tied to 0, with SLT resolved per REQ-026.

Verification (WIDTH=32)
REQ-038 ADD: a=0x0000_0005, b=0x0000_0003, op=0010 -> done high 33 edges after start acceptance, result=0x0000_0008, zero=0, ovf=0.
REQ-039 SUB: a=b=0x1234_5678, op=0110 -> result=0, zero=1; then a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, ovf=1 when SERIAL_ALU_OVF_EN is defined.
REQ-040 SLT: a=0xFFFF_FFFF (-1), b=1 -> result=1; a=0x7FFF_FFFF, b=0x8000_0000 -> result=0, despite overflow.
REQ-041 Logic ops: a=0xF0F0_F0F0, b=0xFF00_FF00 -> AND=0xF000_F000, OR=0xFFF0_FFF0, NOR=0x000F_000F.
REQ-042 start pulsed at RUN cycle 10 with different operands -> ignored, first result unchanged, exactly one done pulse.
REQ-043 rst asserted at RUN cycle 16 -> busy=0, result=0 immediately, no done pulse; next start completes normally.
